// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: round-robin arbiter for two framebuffer writers sharing bRAM port A,
// with a full-buffer clear sequence that takes priority over both writers.
module fb_port_arbiter #(
   parameter int          ADDR_W = 19,
   parameter int          DATA_W = 16,
   parameter int unsigned DEPTH  = 307200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   input  logic              wr0_valid,
   input  logic [ADDR_W-1:0] wr0_addr,
   input  logic [DATA_W-1:0] wr0_data,
   output logic              wr0_ready,
   input  logic              wr1_valid,
   input  logic [ADDR_W-1:0] wr1_addr,
   input  logic [DATA_W-1:0] wr1_data,
   output logic              wr1_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   output logic              busy,
   output logic              clr_done
);
   typedef enum logic {ARB, CLEAR} state_t;
   state_t            state, state_nx;
   logic              ptr;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] color;
   logic              last, grant, in_range;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   always_ff @(posedge clk) state <= rst ? ARB : state_nx;

   always_comb begin
      last     = cnt == ADDR_W'(DEPTH - 1);
      state_nx = state == ARB ? (clr_start ? CLEAR : ARB) : (last ? ARB : CLEAR);
   end

   // ptr names the requester that wins when both are valid
   always_comb begin
      busy      = state == CLEAR;
      wr0_ready = state == ARB && !clr_start && wr0_valid && (!wr1_valid || !ptr);
      wr1_ready = state == ARB && !clr_start && wr1_valid && (!wr0_valid || ptr);
   end

   always_comb begin
      grant    = wr0_ready || wr1_ready;
      sel_addr = wr1_ready ? wr1_addr : wr0_addr;
      sel_data = wr1_ready ? wr1_data : wr0_data;
      in_range = 32'(sel_addr) < DEPTH;
   end

   // out-of-range writes are consumed but leave the port idle and its address/data untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= 1'b0;
         cnt      <= '0;
         color    <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_we   <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         mem_we   <= 1'b0;
         clr_done <= 1'b0;
         if (busy) begin
            mem_addr <= cnt;
            mem_din  <= color;
            mem_we   <= 1'b1;
            cnt      <= last ? '0 : cnt + ADDR_W'(1);
            clr_done <= last;
         end else if (clr_start) begin
            color <= clr_color;
         end else if (grant) begin
            ptr <= wr0_ready;
            if (in_range) begin
               mem_addr <= sel_addr;
               mem_din  <= sel_data;
               mem_we   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed checks of arbitration, write latency, range filtering,
// clear sequencing, clear abort by reset and ignored mid-clear restart requests.
module tb_fb_port_arbiter;
   localparam int AW = 19;
   localparam int DW = 16;
   localparam int D  = 1536;

   logic          clk = 1'b0;
   logic          rst, clr_start, wr0_valid, wr1_valid;
   logic [DW-1:0] clr_color, wr0_data, wr1_data, mem_din;
   logic [AW-1:0] wr0_addr, wr1_addr, mem_addr;
   logic          wr0_ready, wr1_ready, mem_we, busy, clr_done;
   int            checks = 0;
   int            errors = 0;

   fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .clr_start(clr_start), .clr_color(clr_color),
      .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
      .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .busy(busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // follows one clear from its first CLEAR cycle up to the clr_done pulse
   task automatic watch_clear(input logic [DW-1:0] col, input int pulse_at,
                              output int busy_n, output int wr_n, output int bad, output int done_n);
      int cyc = 0;
      busy_n = 0; wr_n = 0; bad = 0; done_n = 0;
      while (done_n == 0 && cyc < 2 * D + 20) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_n++;
         if (mem_we) begin
            if (32'(mem_addr) != wr_n || mem_din != col) bad++;
            wr_n++;
         end
         if (busy && (wr0_ready || wr1_ready)) bad++;
         if (clr_done) done_n++;
         clr_start = (wr_n == pulse_at);
         if (wr_n == pulse_at) clr_color = 16'h1111;
      end
      clr_start = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] ea [4];
      logic [DW-1:0] ed [4];
      int busy_n, wr_n, bad, done_n, found, extra;
      ea[0] = 19'h100; ea[1] = 19'h200; ea[2] = 19'h101; ea[3] = 19'h201;
      ed[0] = 16'hA000; ed[1] = 16'hB000; ed[2] = 16'hA001; ed[3] = 16'hB001;
      rst = 1'b1; clr_start = 1'b0; clr_color = '0;
      wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_din", 32'(mem_din), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_clr_done", 32'(clr_done), 0);

      step;
      wr0_valid = 1'b1; wr0_addr = 19'h00010; wr0_data = 16'hABCD;
      @(negedge clk);
      chk("single_wr0_ready", 32'(wr0_ready), 1);
      chk("single_wr1_ready", 32'(wr1_ready), 0);
      step;
      wr0_valid = 1'b0;
      @(negedge clk);
      chk("single_we", 32'(mem_we), 1);
      chk("single_addr", 32'(mem_addr), 32'h10);
      chk("single_din", 32'(mem_din), 32'hABCD);
      step;
      @(negedge clk);
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_addr_hold", 32'(mem_addr), 32'h10);

      rst = 1'b1;
      step;
      rst = 1'b0;
      wr0_valid = 1'b1; wr0_addr = 19'h100; wr0_data = 16'hA000;
      wr1_valid = 1'b1; wr1_addr = 19'h200; wr1_data = 16'hB000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_ready0", i), 32'(wr0_ready), 32'(i % 2 == 0));
         chk($sformatf("rr%0d_ready1", i), 32'(wr1_ready), 32'(i % 2 == 1));
         if (i > 0) begin
            chk($sformatf("rr%0d_we", i), 32'(mem_we), 1);
            chk($sformatf("rr%0d_addr", i), 32'(mem_addr), 32'(ea[i-1]));
            chk($sformatf("rr%0d_din", i), 32'(mem_din), 32'(ed[i-1]));
         end
         step;
         if (i % 2 == 0) begin wr0_addr = 19'h101; wr0_data = 16'hA001; end
         else begin wr1_addr = 19'h201; wr1_data = 16'hB001; end
      end
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      @(negedge clk);
      chk("rr_last_we", 32'(mem_we), 1);
      chk("rr_last_addr", 32'(mem_addr), 32'(ea[3]));
      chk("rr_last_din", 32'(mem_din), 32'(ed[3]));

      step;
      wr0_valid = 1'b1; wr0_addr = 19'(D); wr0_data = 16'hDEAD;
      @(negedge clk);
      chk("oor_ready", 32'(wr0_ready), 1);
      step;
      wr0_valid = 1'b0;
      @(negedge clk);
      chk("oor_we", 32'(mem_we), 0);
      step;
      wr0_valid = 1'b1; wr0_addr = 19'(D - 1); wr0_data = 16'hBEEF;
      @(negedge clk);
      chk("top_ready", 32'(wr0_ready), 1);
      step;
      wr0_valid = 1'b0;
      @(negedge clk);
      chk("top_we", 32'(mem_we), 1);
      chk("top_addr", 32'(mem_addr), D - 1);

      step;
      clr_start = 1'b1; clr_color = 16'h0F00;
      wr1_valid = 1'b1; wr1_addr = 19'h55; wr1_data = 16'h1234;
      @(negedge clk);
      chk("clr_start_wr1_ready", 32'(wr1_ready), 0);
      step;
      clr_start = 1'b0; clr_color = 16'hFFFF;
      watch_clear(16'h0F00, -1, busy_n, wr_n, bad, done_n);
      chk("clr_done_count", 32'(done_n), 1);
      chk("clr_busy_cycles", 32'(busy_n), D);
      chk("clr_writes", 32'(wr_n), D);
      chk("clr_order_color", 32'(bad), 0);
      chk("clr_end_busy", 32'(busy), 0);
      chk("clr_end_wr1_ready", 32'(wr1_ready), 1);
      step;
      wr1_valid = 1'b0;
      @(negedge clk);
      chk("post_clr_we", 32'(mem_we), 1);
      chk("post_clr_addr", 32'(mem_addr), 32'h55);
      chk("post_clr_din", 32'(mem_din), 32'h1234);

      step;
      clr_start = 1'b1; clr_color = 16'h00AA;
      step;
      clr_start = 1'b0;
      found = 0;
      for (int c = 0; c < 2000 && found == 0; c++) begin
         @(negedge clk);
         if (mem_we && mem_addr == 19'd999) found = 1;
      end
      chk("abort_reach_1000", 32'(found), 1);
      chk("abort_busy_before", 32'(busy), 1);
      rst = 1'b1;
      step;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_we", 32'(mem_we), 0);
      chk("abort_clr_done", 32'(clr_done), 0);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         extra += int'(clr_done) + int'(busy);
      end
      chk("abort_quiet", 32'(extra), 0);

      step;
      clr_start = 1'b1; clr_color = 16'h00AA;
      step;
      clr_start = 1'b0;
      watch_clear(16'h00AA, 500, busy_n, wr_n, bad, done_n);
      chk("restart_done_count", 32'(done_n), 1);
      chk("restart_busy_cycles", 32'(busy_n), D);
      chk("restart_writes", 32'(wr_n), D);
      chk("restart_order_color", 32'(bad), 0);
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         extra += int'(clr_done) + int'(busy);
      end
      chk("restart_no_second_clear", 32'(extra), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
